// File: rtl/fifo_flex_if.sv
// Handshake/data bundle between the producer/consumer side and the fifo_flex core.
// Handshake semantics: a write is taken on a rising edge when cs & wr_en & !full,
// a read is taken when cs & rd_en & !empty; full/empty act as the inverse ready
// signals and are decoded from registered state only, so they never depend on
// the request inputs of the same cycle.
interface fifo_flex_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) ();
  localparam int AW = $clog2(DEPTH);

  logic                  cs;
  logic                  wr_en;
  logic                  rd_en;
  logic                  flush;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [AW:0]           count;
  logic                  overflow;
  logic                  underflow;

  // Producer/consumer side: drives requests and data, observes status.
  modport master (
    output cs, wr_en, rd_en, flush, clr_err, din,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  cs, wr_en, rd_en, flush, clr_err, din,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flex.sv
// Single-clock FIFO with watermarks, occupancy count, sticky error flags,
// synchronous flush and a selectable first-word-fall-through read port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fifo_flex #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic       clk,
  input  logic       rst,
  fifo_flex_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t AF_P    = ptr_t'(AF_THRESH);
  localparam ptr_t AE_P    = ptr_t'(AE_THRESH);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t count;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;
  logic full, empty;
  logic flush_acc, wr_acc, rd_acc;
  logic ov_set, uf_set;
  logic [AW-1:0] rd_addr;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Status decode is purely from the registered pointers.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == DEPTH_P);
  assign empty   = (count == '0);
  assign rd_addr = rd_ptr_q[AW-1:0];

  // Flush wins over everything; requests in a flush cycle are dropped silently.
  assign flush_acc = bus.cs & bus.flush;
  assign wr_acc    = bus.cs & bus.wr_en & ~full  & ~flush_acc;
  assign rd_acc    = bus.cs & bus.rd_en & ~empty & ~flush_acc;
  assign ov_set    = bus.cs & bus.wr_en & full  & ~flush_acc;
  assign uf_set    = bus.cs & bus.rd_en & empty & ~flush_acc;

  // Next-state for pointers and sticky error flags (set beats clear).
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush_acc) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ov_set) overflow_d  = 1'b1;
    if (uf_set) underflow_d = 1'b1;
  end

  // Pointer and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= bus.din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented directly; meaningless while empty.
      assign bus.dout = mem_q[rd_addr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      // Registered read port: loads the head entry on an accepted pop.
      always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = mem_q[rd_addr];
      end

      // Read data register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) dout_q <= '0;
        else     dout_q <= dout_d;
      end

      assign bus.dout = dout_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_P);
  assign bus.almost_empty = (count <= AE_P);
  assign bus.count        = count;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: a standard-mode instance and an FWFT instance
// share clock and reset; expected data comes from a queue of written words.
module tb_fifo_flex;
  localparam int DW = 32;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if_s ();
  fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if_f ();

  fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0))
    u_std (.clk(clk), .rst(rst), .bus(if_s.slave));
  fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1))
    u_fw (.clk(clk), .rst(rst), .bus(if_f.slave));

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_dout;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_s(input logic ce, input logic wr, input logic rd, input logic fl,
                         input logic clr, input logic [DW-1:0] d);
    if_s.cs = ce; if_s.wr_en = wr; if_s.rd_en = rd; if_s.flush = fl;
    if_s.clr_err = clr; if_s.din = d;
  endtask

  task automatic drive_f(input logic wr, input logic rd, input logic [DW-1:0] d);
    if_f.cs = 1'b1; if_f.wr_en = wr; if_f.rd_en = rd; if_f.flush = 1'b0;
    if_f.clr_err = 1'b0; if_f.din = d;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive_s(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive_f(1'b0, 1'b0, '0);
    step();
    step();

    // Reset state
    check("rst_empty", 32'(if_s.empty), 32'd1);
    check("rst_full", 32'(if_s.full), 32'd0);
    check("rst_ae", 32'(if_s.almost_empty), 32'd1);
    check("rst_af", 32'(if_s.almost_full), 32'd0);
    check("rst_count", 32'(if_s.count), 32'd0);
    check("rst_ov", 32'(if_s.overflow), 32'd0);
    check("rst_uf", 32'(if_s.underflow), 32'd0);
    check("rst_dout", if_s.dout, 32'd0);
    rst = 1'b0;

    // Fill with 0x11..0x88; watermarks tracked per write
    for (int i = 0; i < 8; i++) begin
      drive_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11 * (i + 1));
      exp_q.push_back(32'h11 * (i + 1));
      step();
      check("fill_count", 32'(if_s.count), 32'(i + 1));
      check("fill_ae", 32'(if_s.almost_empty), ((i + 1) <= 2) ? 32'd1 : 32'd0);
      check("fill_af", 32'(if_s.almost_full), ((i + 1) >= 6) ? 32'd1 : 32'd0);
    end
    check("fill_full", 32'(if_s.full), 32'd1);

    // 9th write while full is rejected and flagged
    drive_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h99);
    step();
    check("ovf_flag", 32'(if_s.overflow), 32'd1);
    check("ovf_count", 32'(if_s.count), 32'd8);

    // Drain all 8 in order
    for (int i = 0; i < 8; i++) begin
      drive_s(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      step();
      last_dout = exp_q.pop_front();
      check("drain_dout", if_s.dout, last_dout);
      check("drain_count", 32'(if_s.count), 32'(7 - i));
      check("drain_af", 32'(if_s.almost_full), ((7 - i) >= 6) ? 32'd1 : 32'd0);
    end
    check("drain_empty", 32'(if_s.empty), 32'd1);

    // Read while empty
    drive_s(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step();
    check("udf_flag", 32'(if_s.underflow), 32'd1);
    check("udf_dout_hold", if_s.dout, last_dout);
    check("udf_count", 32'(if_s.count), 32'd0);

    // Clear errors
    drive_s(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    step();
    check("clr_ov", 32'(if_s.overflow), 32'd0);
    check("clr_uf", 32'(if_s.underflow), 32'd0);

    // Set beats clear in the same cycle
    drive_s(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
    step();
    check("setwins_uf", 32'(if_s.underflow), 32'd1);

    // Preload 4 then stream read+write for 20 cycles across pointer wrap
    for (int i = 0; i < 4; i++) begin
      drive_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100 + i);
      exp_q.push_back(32'h100 + i);
      step();
    end
    check("pre_count", 32'(if_s.count), 32'd4);
    for (int i = 0; i < 20; i++) begin
      drive_s(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200 + i);
      exp_q.push_back(32'h200 + i);
      step();
      last_dout = exp_q.pop_front();
      check("stream_dout", if_s.dout, last_dout);
      check("stream_count", 32'(if_s.count), 32'd4);
    end

    // Fill up, then read+write while full: read taken, write refused
    for (int i = 0; i < 4; i++) begin
      drive_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300 + i);
      exp_q.push_back(32'h300 + i);
      step();
    end
    check("full2_full", 32'(if_s.full), 32'd1);
    drive_s(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD);
    step();
    last_dout = exp_q.pop_front();
    check("fullrw_dout", if_s.dout, last_dout);
    check("fullrw_count", 32'(if_s.count), 32'd7);
    check("fullrw_ov", 32'(if_s.overflow), 32'd1);
    for (int i = 0; i < 7; i++) begin
      drive_s(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      step();
      last_dout = exp_q.pop_front();
      check("drain2_dout", if_s.dout, last_dout);
    end
    check("drain2_empty", 32'(if_s.empty), 32'd1);

    // Flush with a concurrent write at count=5
    for (int i = 0; i < 5; i++) begin
      drive_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400 + i);
      step();
    end
    check("preflush_count", 32'(if_s.count), 32'd5);
    drive_s(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hBEEF);
    step();
    check("flush_count", 32'(if_s.count), 32'd0);
    check("flush_empty", 32'(if_s.empty), 32'd1);
    check("flush_ov", 32'(if_s.overflow), 32'd1);
    check("flush_dout_hold", if_s.dout, last_dout);

    // Chip-select low ignores requests
    drive_s(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    step();
    drive_s(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h55);
    step();
    check("cs_count", 32'(if_s.count), 32'd0);
    check("cs_uf", 32'(if_s.underflow), 32'd0);

    // FWFT instance: word visible without a read
    drive_s(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive_f(1'b1, 1'b0, 32'hA5);
    step();
    check("fw_dout1", if_f.dout, 32'hA5);
    check("fw_empty1", 32'(if_f.empty), 32'd0);
    drive_f(1'b1, 1'b0, 32'h5A);
    step();
    check("fw_dout2", if_f.dout, 32'hA5);
    check("fw_count2", 32'(if_f.count), 32'd2);
    drive_f(1'b0, 1'b1, '0);
    step();
    check("fw_dout3", if_f.dout, 32'h5A);
    drive_f(1'b0, 1'b1, '0);
    step();
    check("fw_empty4", 32'(if_f.empty), 32'd1);
    drive_f(1'b0, 1'b0, '0);

    // Asynchronous reset mid-stream
    drive_s(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step();
    check("pre_rst_uf", 32'(if_s.underflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500 + i);
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 32'(if_s.count), 32'd0);
    check("arst_empty", 32'(if_s.empty), 32'd1);
    check("arst_uf", 32'(if_s.underflow), 32'd0);
    check("arst_dout", if_s.dout, 32'd0);
    check("arst_ae", 32'(if_s.almost_empty), 32'd1);
    step();
    rst = 1'b0;
    drive_s(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h77);
    step();
    check("post_rst_count", 32'(if_s.count), 32'd1);
    drive_s(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step();
    check("post_rst_dout", if_s.dout, 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
